// File: rtl/modulo_dispensador_rolhas.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : modulo_dispensador_rolhas                                  |
// | Description : Cork-stock consumer. Owns the 7-bit cork count, dispenses  |
// |               one cork per capping request, refuses requests on empty    |
// |               stock and runs a req/ack refill handshake with the feeder. |
// | Ports       : clk, rst        - clock, synchronous active-high reset     |
// |               pedido          - capping request (level, used in IDLE)    |
// |               rep_ack,rep_qtd - feeder acknowledge pulse and quantity    |
// |               atuador         - dispenser actuator drive                 |
// |               vedado          - pulse: cork dispensed, bottle sealed     |
// |               sem_rolha       - pulse: request refused, stock empty      |
// |               rep_req         - refill request to feeder (level)         |
// |               estoque         - current cork count (display)             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module modulo_dispensador_rolhas #(
    parameter int MAX_ROLHAS  = 99,
    parameter int LIMIAR_REP  = 5,
    parameter int CICLOS_ATUA = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pedido,
    input  logic       rep_ack,
    input  logic [6:0] rep_qtd,
    output logic       atuador,
    output logic       vedado,
    output logic       sem_rolha,
    output logic       rep_req,
    output logic [6:0] estoque
);

    localparam int CW = (CICLOS_ATUA > 1) ? $clog2(CICLOS_ATUA) : 1;

    localparam logic [CW-1:0] c_CNT_FIM = CW'(CICLOS_ATUA - 1);
    localparam logic [7:0]    c_MAX8    = 8'(MAX_ROLHAS);
    localparam logic [6:0]    c_MAX7    = 7'(MAX_ROLHAS);
    localparam logic [6:0]    c_LIMIAR  = 7'(LIMIAR_REP);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPENSA = 2'd1;
    localparam logic [1:0] S_CONCLUI  = 2'd2;
    localparam logic [1:0] S_RECUSA   = 2'd3;

    logic [1:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [6:0]    estoque_q, estoque_d;
    logic          rep_req_q, rep_req_d;
    logic          bloq_q,    bloq_d;    // suppresses rep_req the cycle after an ack

    logic          w_dec;                // stock decrement on the DISPENSA->CONCLUI edge
    logic          w_ack;
    logic [7:0]    w_soma;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            estoque_q <= '0;
            rep_req_q <= 1'b0;
            bloq_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            estoque_q <= estoque_d;
            rep_req_q <= rep_req_d;
            bloq_q    <= bloq_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_dec   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pedido) begin
                    if (estoque_q != 7'd0) begin
                        state_d = S_DISPENSA;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RECUSA;
                    end
                end
            end
            S_DISPENSA: begin
                if (cnt_q == c_CNT_FIM) begin
                    // Decrement lands together with vedado in the CONCLUI cycle
                    state_d = S_CONCLUI;
                    w_dec   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // RECUSA is a one-cycle gap so a held request pulses sem_rolha 1,0,1,0
            S_CONCLUI: state_d = S_IDLE;
            S_RECUSA:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Stock arithmetic and refill handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_ack  = rep_ack & rep_req_q;
        // DISPENSA is entered only with stock > 0 and stock never drops
        // mid-dispense, so the subtraction cannot wrap.
        w_soma = {1'b0, estoque_q}
               + (w_ack ? {1'b0, rep_qtd} : 8'd0)
               - {7'd0, w_dec};
        if (w_soma > c_MAX8) begin
            estoque_d = c_MAX7;
        end else begin
            estoque_d = w_soma[6:0];
        end

        bloq_d = w_ack;
        if (w_ack) begin
            rep_req_d = 1'b0;
        end else if (rep_req_q) begin
            rep_req_d = 1'b1;
        end else begin
            rep_req_d = !bloq_q && (estoque_q <= c_LIMIAR);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers, forced low while rst is high
    // ------------------------------------------------------------------
    always_comb begin
        atuador   = !rst && (state_q == S_DISPENSA);
        vedado    = !rst && (state_q == S_CONCLUI);
        sem_rolha = !rst && (state_q == S_RECUSA);
        rep_req   = !rst && rep_req_q;
        estoque   = rst ? 7'd0 : estoque_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_modulo_dispensador_rolhas.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_modulo_dispensador_rolhas                               |
// | Description : Directed self-checking bench for modulo_dispensador_rolhas |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_modulo_dispensador_rolhas;

    logic       clk;
    logic       rst;
    logic       pedido;
    logic       rep_ack;
    logic [6:0] rep_qtd;
    logic       atuador;
    logic       vedado;
    logic       sem_rolha;
    logic       rep_req;
    logic [6:0] estoque;

    int compared   = 0;
    int mismatched = 0;

    modulo_dispensador_rolhas #(
        .MAX_ROLHAS  (99),
        .LIMIAR_REP  (5),
        .CICLOS_ATUA (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pedido    (pedido),
        .rep_ack   (rep_ack),
        .rep_qtd   (rep_qtd),
        .atuador   (atuador),
        .vedado    (vedado),
        .sem_rolha (sem_rolha),
        .rep_req   (rep_req),
        .estoque   (estoque)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample and drive 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pedido = 1'b0; rep_ack = 1'b0; rep_qtd = 7'd0;

        // ---- 1. reset, first-edge refill request, ack with 20 ----
        step();
        chk("rst_estoque",   {1'b0, estoque}, 8'd0);
        chk("rst_rep_req",   {7'd0, rep_req}, 8'd0);
        chk("rst_atuador",   {7'd0, atuador}, 8'd0);
        chk("rst_vedado",    {7'd0, vedado}, 8'd0);
        chk("rst_sem_rolha", {7'd0, sem_rolha}, 8'd0);
        step();
        rst = 1'b0;
        chk("req_before_edge", {7'd0, rep_req}, 8'd0);
        step();
        chk("req_first_edge", {7'd0, rep_req}, 8'd1);
        step();
        step();
        chk("req_held", {7'd0, rep_req}, 8'd1);
        rep_ack = 1'b1; rep_qtd = 7'd20;
        step();
        rep_ack = 1'b0; rep_qtd = 7'd0;
        chk("ack20_estoque", {1'b0, estoque}, 8'd20);
        chk("ack20_req_clr", {7'd0, rep_req}, 8'd0);

        // spurious ack without a pending request is ignored
        rep_ack = 1'b1; rep_qtd = 7'd7;
        step();
        rep_ack = 1'b0; rep_qtd = 7'd0;
        chk("spurious_ack", {1'b0, estoque}, 8'd20);

        // ---- 2. single dispense from 20 ----
        pedido = 1'b1;
        step();
        pedido = 1'b0;
        chk("disp_atu_c1", {7'd0, atuador}, 8'd1);
        chk("disp_ved_c1", {7'd0, vedado}, 8'd0);
        step();
        chk("disp_atu_c2", {7'd0, atuador}, 8'd1);
        step();
        chk("disp_atu_c3", {7'd0, atuador}, 8'd1);
        chk("disp_est_c3", {1'b0, estoque}, 8'd20);
        step();
        chk("disp_atu_c4", {7'd0, atuador}, 8'd0);
        chk("disp_ved_c4", {7'd0, vedado}, 8'd1);
        chk("disp_est_c4", {1'b0, estoque}, 8'd19);
        step();
        chk("disp_ved_c5", {7'd0, vedado}, 8'd0);

        // ---- 3. empty stock, request held 4 cycles ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        pedido = 1'b1;
        step();
        chk("sem_c1", {7'd0, sem_rolha}, 8'd1);
        step();
        chk("sem_c2", {7'd0, sem_rolha}, 8'd0);
        step();
        chk("sem_c3", {7'd0, sem_rolha}, 8'd1);
        step();
        pedido = 1'b0;
        chk("sem_c4", {7'd0, sem_rolha}, 8'd0);
        chk("sem_atu", {7'd0, atuador}, 8'd0);
        step();
        chk("sem_c5", {7'd0, sem_rolha}, 8'd0);
        chk("sem_atu2", {7'd0, atuador}, 8'd0);

        // ack with quantity 0: count unchanged, one-cycle re-assert block
        chk("q0_req_pre", {7'd0, rep_req}, 8'd1);
        rep_ack = 1'b1; rep_qtd = 7'd0;
        step();
        rep_ack = 1'b0;
        chk("q0_estoque", {1'b0, estoque}, 8'd0);
        chk("q0_req_clr", {7'd0, rep_req}, 8'd0);
        step();
        chk("q0_req_blocked", {7'd0, rep_req}, 8'd0);
        step();
        chk("q0_req_again", {7'd0, rep_req}, 8'd1);

        // ---- 4. stock 6, dispense to threshold, saturating refill ----
        rep_ack = 1'b1; rep_qtd = 7'd6;
        step();
        rep_ack = 1'b0; rep_qtd = 7'd0;
        chk("t4_estoque6", {1'b0, estoque}, 8'd6);
        step();
        step();
        chk("t4_req_idle", {7'd0, rep_req}, 8'd0);
        pedido = 1'b1;
        step();
        pedido = 1'b0;
        step();
        step();
        step();
        chk("t4_estoque5", {1'b0, estoque}, 8'd5);
        chk("t4_vedado", {7'd0, vedado}, 8'd1);
        chk("t4_req_not_yet", {7'd0, rep_req}, 8'd0);
        step();
        chk("t4_req_set", {7'd0, rep_req}, 8'd1);
        rep_ack = 1'b1; rep_qtd = 7'd120;
        step();
        rep_ack = 1'b0; rep_qtd = 7'd0;
        chk("t4_saturated", {1'b0, estoque}, 8'd99);
        chk("t4_req_clr", {7'd0, rep_req}, 8'd0);

        // ---- 5. ack coincident with the decrement edge ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        rep_ack = 1'b1; rep_qtd = 7'd5;
        step();
        rep_ack = 1'b0; rep_qtd = 7'd0;
        chk("t5_estoque5", {1'b0, estoque}, 8'd5);
        step();
        step();
        chk("t5_req", {7'd0, rep_req}, 8'd1);
        pedido = 1'b1;
        step();
        pedido = 1'b0;
        step();
        step();
        rep_ack = 1'b1; rep_qtd = 7'd10;
        step();
        rep_ack = 1'b0; rep_qtd = 7'd0;
        chk("t5_estoque14", {1'b0, estoque}, 8'd14);
        chk("t5_vedado", {7'd0, vedado}, 8'd1);
        chk("t5_req_clr", {7'd0, rep_req}, 8'd0);

        // ---- 6. reset during the 2nd actuator cycle ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        rep_ack = 1'b1; rep_qtd = 7'd30;
        step();
        rep_ack = 1'b0; rep_qtd = 7'd0;
        chk("t6_estoque30", {1'b0, estoque}, 8'd30);
        pedido = 1'b1;
        step();
        pedido = 1'b0;
        chk("t6_atu_c1", {7'd0, atuador}, 8'd1);
        step();
        chk("t6_atu_c2", {7'd0, atuador}, 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_estoque0", {1'b0, estoque}, 8'd0);
        chk("t6_atuador", {7'd0, atuador}, 8'd0);
        chk("t6_vedado", {7'd0, vedado}, 8'd0);
        chk("t6_sem_rolha", {7'd0, sem_rolha}, 8'd0);
        chk("t6_rep_req", {7'd0, rep_req}, 8'd0);
        step();
        chk("t6_no_vedado", {7'd0, vedado}, 8'd0);
        chk("t6_estoque_hold", {1'b0, estoque}, 8'd0);
        chk("t6_req_rises", {7'd0, rep_req}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
